// File: rtl/flash_read_arbiter_if.sv
// Request/flash bundle for flash_read_arbiter; slave is the arbiter's view, master the environment's.
// No latency or flow control of its own: a plain signal bundle.
interface flash_read_arbiter_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  req0_en;
    logic [ADDR_WIDTH-1:0] req0_address;
    logic                  req0_ready;
    logic                  req1_en;
    logic [ADDR_WIDTH-1:0] req1_address;
    logic                  req1_ready;
    logic [31:0]           read_data;
    logic                  flash_read_en;
    logic [ADDR_WIDTH-1:0] flash_read_address;
    logic                  flash_read_ready;
    logic [31:0]           flash_read_data;
    logic                  busy;
    logic                  timeout_flag;

    modport slave (
        input  req0_en, req0_address, req1_en, req1_address,
               flash_read_ready, flash_read_data,
        output req0_ready, req1_ready, read_data, flash_read_en,
               flash_read_address, busy, timeout_flag
    );

    modport master (
        output req0_en, req0_address, req1_en, req1_address,
               flash_read_ready, flash_read_data,
        input  req0_ready, req1_ready, read_data, flash_read_en,
               flash_read_address, busy, timeout_flag
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-port arbiter onto the flash_dma read port (FLASH_READ_ARBITER_ROUND_ROBIN_EN selects round robin); grant one cycle after
// request, ready one cycle after flash_read_ready, then one RETIRE cycle; requesters hold en until ready, watchdog aborts stalls.
module flash_read_arbiter #(
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   resetn,
    flash_read_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RETIRE} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  flash_read_en_q, flash_read_en_d;
    logic [ADDR_WIDTH-1:0] flash_read_address_q, flash_read_address_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  req0_ready_q, req0_ready_d;
    logic                  req1_ready_q, req1_ready_d;
    logic                  busy_q, busy_d;
    logic                  timeout_flag_q, timeout_flag_d;
    logic                  winner;
    logic                  done;

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        grant_d              = grant_q;
        last_grant_d         = last_grant_q;
        flash_read_en_d      = flash_read_en_q;
        flash_read_address_d = flash_read_address_q;
        read_data_d          = read_data_q;
        req0_ready_d         = 1'b0;
        req1_ready_d         = 1'b0;
        timeout_flag_d       = timeout_flag_q;
        winner               = 1'b0;
        done                 = 1'b0;

`ifdef FLASH_READ_ARBITER_ROUND_ROBIN_EN
        if (bus.req0_en && bus.req1_en) winner = ~last_grant_q;
        else                            winner = ~bus.req0_en;
`else
        winner = ~bus.req0_en;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.req0_en || bus.req1_en) begin
                    grant_d              = winner;
                    last_grant_d         = winner;
                    flash_read_address_d = winner ? bus.req1_address : bus.req0_address;
                    flash_read_en_d      = 1'b1;
                    cnt_d                = '0;
                    state_d              = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion landing on the timeout edge takes precedence over the abort.
                if (bus.flash_read_ready) begin
                    read_data_d = bus.flash_read_data;
                    done        = 1'b1;
                end else if (WDOG_EN && (cnt_q == TO_LAST)) begin
                    read_data_d    = 32'hFFFF_FFFF;
                    timeout_flag_d = 1'b1;
                    done           = 1'b1;
                end
                if (done) begin
                    req0_ready_d    = ~grant_q;
                    req1_ready_d    = grant_q;
                    flash_read_en_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = ST_RETIRE;
                end
            end
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q              <= ST_IDLE;
            cnt_q                <= '0;
            grant_q              <= 1'b0;
            last_grant_q         <= 1'b1;
            flash_read_en_q      <= 1'b0;
            flash_read_address_q <= '0;
            read_data_q          <= '0;
            req0_ready_q         <= 1'b0;
            req1_ready_q         <= 1'b0;
            busy_q               <= 1'b0;
            timeout_flag_q       <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            grant_q              <= grant_d;
            last_grant_q         <= last_grant_d;
            flash_read_en_q      <= flash_read_en_d;
            flash_read_address_q <= flash_read_address_d;
            read_data_q          <= read_data_d;
            req0_ready_q         <= req0_ready_d;
            req1_ready_q         <= req1_ready_d;
            busy_q               <= busy_d;
            timeout_flag_q       <= timeout_flag_d;
        end
    end

    assign bus.req0_ready         = req0_ready_q;
    assign bus.req1_ready         = req1_ready_q;
    assign bus.read_data          = read_data_q;
    assign bus.flash_read_en      = flash_read_en_q;
    assign bus.flash_read_address = flash_read_address_q;
    assign bus.busy               = busy_q;
    assign bus.timeout_flag       = timeout_flag_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: expected reads queued at issue, checked at each ready pulse.
module tb_flash_read_arbiter;
    localparam int AW  = 20;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    flash_read_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    flash_read_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit          port;
        logic [AW-1:0] addr;
        logic [31:0] data;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   en_rise_cyc = 0;
    int   hold_left = 0;
    int   flash_lat = 10;
    bit   flash_hang = 1'b0;
    bit   prev_en = 1'b0;
    bit   busy_next = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [AW-1:0] a);
        return (a == 20'h01234) ? 32'hDEADBEEF : {12'hC0D, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model and requester behaviour: drop en once the port's ready is seen.
    initial begin : flash_model
        int  fcnt;
        bit  resp;
        fcnt = 0;
        resp = 1'b0;
        bus.flash_read_ready = 1'b0;
        bus.flash_read_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.flash_read_ready = 1'b0;
            if (bus.req0_ready || bus.req1_ready) begin
                if (hold_left > 1) begin
                    hold_left--;
                end else if (hold_left == 1) begin
                    hold_left   = 0;
                    bus.req0_en = 1'b0;
                    bus.req1_en = 1'b0;
                end else begin
                    if (bus.req0_ready) bus.req0_en = 1'b0;
                    if (bus.req1_ready) bus.req1_en = 1'b0;
                end
            end
            if (!bus.flash_read_en) begin
                fcnt = 0;
                resp = 1'b0;
            end else if (!resp) begin
                fcnt++;
                if (!flash_hang && fcnt >= flash_lat) begin
                    bus.flash_read_ready = 1'b1;
                    bus.flash_read_data  = data_of(bus.flash_read_address);
                    resp = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_en   = 1'b0;
                busy_next = 1'b0;
            end else begin
                if (busy_next) begin
                    chk("busy_after_retire", bus.busy, 1'b0);
                    busy_next = 1'b0;
                end
                if (bus.flash_read_en && !prev_en) begin
                    en_rise_cyc = cyc;
                    if (sb.size() != 0) chk("grant_addr", bus.flash_read_address, sb[0].addr);
                end
                prev_en = bus.flash_read_en;
                if (bus.req0_ready || bus.req1_ready) begin
                    chk("one_hot_ready", bus.req0_ready & bus.req1_ready, 1'b0);
                    chk("ready_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        chk("ready_port", bus.req1_ready, mon_e.port);
                        chk("read_data", bus.read_data, mon_e.data);
                        chk("addr_held", bus.flash_read_address, mon_e.addr);
                        chk("busy_in_ready", bus.busy, 1'b1);
                        if (mon_e.tmo) begin
                            chk("tmo_latency", cyc - en_rise_cyc, TMO);
                            chk("tmo_flag_set", bus.timeout_flag, 1'b1);
                        end
                        done_cnt++;
                        busy_next = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit port, input logic [AW-1:0] a);
        exp_t e;
        e.port = port;
        e.addr = a;
        e.tmo  = flash_hang;
        e.data = flash_hang ? 32'hFFFF_FFFF : data_of(a);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        chk("wait_done", done_cnt, target);
    endtask

    task automatic do_read(input bit port, input logic [AW-1:0] a);
        int tgt;
        tgt = done_cnt + 1;
        @(posedge clk);
        #1;
        push_exp(port, a);
        if (port) begin bus.req1_address = a; bus.req1_en = 1'b1; end
        else      begin bus.req0_address = a; bus.req0_en = 1'b1; end
        wait_done(tgt, 300);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin : main
        int tgt;
        resetn           = 1'b0;
        bus.req0_en      = 1'b0;
        bus.req1_en      = 1'b0;
        bus.req0_address = '0;
        bus.req1_address = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", bus.flash_read_en, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rdy0", bus.req0_ready, 1'b0);
        chk("rst_rdy1", bus.req1_ready, 1'b0);
        chk("rst_data", bus.read_data, 32'h0);
        chk("rst_tflag", bus.timeout_flag, 1'b0);
        chk("rst_addr", bus.flash_read_address, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // Single read
        do_read(1'b0, 20'h01234);

        // Address changed while BUSY must not reach flash_dma
        tgt = done_cnt + 1;
        @(posedge clk);
        #1;
        push_exp(1'b0, 20'h00100);
        bus.req0_address = 20'h00100;
        bus.req0_en      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.req0_address = 20'h00200;
        wait_done(tgt, 300);

        // Simultaneous requests after reset: port 0 first in either arbitration mode
        pulse_reset();
        tgt = done_cnt + 2;
        @(posedge clk);
        #1;
        push_exp(1'b0, 20'h00010);
        push_exp(1'b1, 20'h00020);
        bus.req0_address = 20'h00010;
        bus.req1_address = 20'h00020;
        bus.req0_en      = 1'b1;
        bus.req1_en      = 1'b1;
        wait_done(tgt, 300);

        // Reset five cycles into BUSY
        @(posedge clk);
        #1;
        bus.req0_address = 20'h00555;
        bus.req0_en      = 1'b1;
        for (int i = 0; i < 20 && !bus.flash_read_en; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_en", bus.flash_read_en, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_rdy", {bus.req0_ready, bus.req1_ready}, 2'b00);
        bus.req0_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_read(1'b0, 20'h00777);

        // Both ports held for six transactions
        pulse_reset();
        tgt = done_cnt + 6;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
`ifdef FLASH_READ_ARBITER_ROUND_ROBIN_EN
            push_exp(i[0], i[0] ? 20'h00050 : 20'h00040);
`else
            push_exp(1'b0, 20'h00040);
`endif
        end
        hold_left        = 6;
        bus.req0_address = 20'h00040;
        bus.req1_address = 20'h00050;
        bus.req0_en      = 1'b1;
        bus.req1_en      = 1'b1;
        wait_done(tgt, 600);

        // Watchdog abort, then flag must survive a normal read
        flash_hang = 1'b1;
        do_read(1'b1, 20'h00333);
        flash_hang = 1'b0;
        do_read(1'b0, 20'h00444);
        chk("tmo_sticky", bus.timeout_flag, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
